aes_encrypt_sched: RTL and testbench

Round-robin scheduler that shares one iterative `aes_encrypt` core between `NREQ` requesters. It accepts one plaintext block at a time over per-requester valid/ready handshakes, pulses the core's `load`, waits for the core's `valid`, and returns the ciphertext tagged with the requester ID. It sits between the block clients and the single `aes_encrypt` instance. The key is wired to the core directly and is not handled here.

---
 rtl/aes_sched_pkg.sv | 14 +
 rtl/aes_encrypt_sched_arbiter.sv | 37 +++
 rtl/aes_encrypt_sched.sv | 154 +++++++++++++++
 tb/tb_aes_encrypt_sched.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the round-robin AES core scheduler.
package aes_sched_pkg;

    localparam int unsigned AES_BLK_W       = 128;
    localparam int unsigned TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BUSY,
        RESP
    } sched_state_e;

endpackage

// File: rtl/aes_encrypt_sched_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id
);

    logic [IW-1:0] idx;
    int unsigned   idx_full;
    logic          found;

    always_comb begin
        gnt      = '0;
        gnt_id   = '0;
        found    = 1'b0;
        idx      = '0;
        idx_full = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx_full = 32'(ptr) + k;
            if (idx_full >= N) begin
                idx_full = idx_full - N;
            end
            idx = IW'(idx_full);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/aes_encrypt_sched.sv
// Round-robin scheduler sharing one iterative aes_encrypt core between NREQ
// requesters. Optional BUSY watchdog enabled by defining AES_SCHED_WATCHDOG_EN.
module aes_encrypt_sched
    import aes_sched_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = $clog2(NREQ),
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [AES_BLK_W*NREQ-1:0] req_pt,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic [AES_BLK_W-1:0]      rsp_ct,
    output logic                      rsp_err,
    output logic                      core_load,
    output logic [AES_BLK_W-1:0]      core_pt,
    input  logic [AES_BLK_W-1:0]      core_ct,
    input  logic                      core_valid
);

    sched_state_e         state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [AES_BLK_W-1:0] core_pt_q, core_pt_d;
    logic [AES_BLK_W-1:0] rsp_ct_q, rsp_ct_d;
    logic                 core_load_q, core_load_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [NREQ-1:0]      arb_gnt;
    logic [IDW-1:0]       arb_id;
    logic                 grant;
    logic                 wd_expired;

`ifdef AES_SCHED_WATCHDOG_EN
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_q, wd_d;
    assign wd_expired = (wd_q == WDW'(TIMEOUT));
`else
    assign wd_expired = 1'b0;
`endif

    rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .gnt    (arb_gnt),
        .gnt_id (arb_id)
    );

    // Gated by rst_n so no grant is offered while reset is held.
    assign req_ready = (state_q == IDLE && rst_n) ? arb_gnt : '0;
    assign grant     = |req_ready;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        core_pt_d   = core_pt_q;
        rsp_ct_d    = rsp_ct_q;
        core_load_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
`ifdef AES_SCHED_WATCHDOG_EN
        wd_d        = wd_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (arb_gnt[i]) begin
                            core_pt_d = req_pt[i*AES_BLK_W +: AES_BLK_W];
                        end
                    end
                    id_d        = arb_id;
                    rr_ptr_d    = (arb_id == IDW'(NREQ - 1)) ? '0 : arb_id + 1'b1;
                    core_load_d = 1'b1;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                state_d = BUSY;
`ifdef AES_SCHED_WATCHDOG_EN
                wd_d    = '0;
`endif
            end
            BUSY: begin
                // A core result on the limit cycle takes priority over the abort.
                if (core_valid) begin
                    rsp_ct_d    = core_ct;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (wd_expired) begin
                    rsp_ct_d    = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
`ifdef AES_SCHED_WATCHDOG_EN
                    wd_d = wd_q + 1'b1;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            core_pt_q   <= '0;
            rsp_ct_q    <= '0;
            core_load_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
`ifdef AES_SCHED_WATCHDOG_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            core_pt_q   <= core_pt_d;
            rsp_ct_q    <= rsp_ct_d;
            core_load_q <= core_load_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
`ifdef AES_SCHED_WATCHDOG_EN
            wd_q        <= wd_d;
`endif
        end
    end

    assign core_load = core_load_q;
    assign core_pt   = core_pt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_ct    = rsp_ct_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_aes_encrypt_sched.sv
// Self-checking bench for aes_encrypt_sched with a stub AES core and a
// transaction-level scoreboard of grants and responses.
module tb_aes_encrypt_sched;

    localparam int N = 4;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid, req_ready;
    logic [128*N-1:0] req_pt;
    logic             rsp_valid, rsp_ready, rsp_err, core_load, core_valid;
    logic [1:0]       rsp_id;
    logic [127:0]     rsp_ct, core_pt, core_ct;

    aes_encrypt_sched #(.NREQ(N), .IDW(2), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_pt     (req_pt),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_ct     (rsp_ct),
        .rsp_err    (rsp_err),
        .core_load  (core_load),
        .core_pt    (core_pt),
        .core_ct    (core_ct),
        .core_valid (core_valid)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // Stand-in for the AES core: FIPS-197 vector maps to its known ciphertext,
    // any other block to a fixed scramble.
    function automatic logic [127:0] ref_ct(input logic [127:0] pt);
        if (pt == FIPS_PT) return FIPS_CT;
        return {pt[63:0], pt[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    function automatic logic [N-1:0] exp_gnt(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return N'(1) << ((p + k) % N);
        return '0;
    endfunction

    logic         spur, mute, wd_mode;
    logic         stub_valid, sb_busy;
    int           sb_cnt;
    logic [127:0] sb_pt, stub_ct;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_busy <= 1'b0; sb_cnt <= 0; stub_valid <= 1'b0; stub_ct <= '0; sb_pt <= '0;
        end else begin
            stub_valid <= 1'b0;
            if (core_load) begin
                sb_busy <= 1'b1; sb_cnt <= int'($urandom_range(3, 8)); sb_pt <= core_pt;
            end else if (sb_busy && !mute) begin
                if (sb_cnt == 1) begin
                    stub_valid <= 1'b1; stub_ct <= ref_ct(sb_pt); sb_busy <= 1'b0;
                end else begin
                    sb_cnt <= sb_cnt - 1;
                end
            end
        end
    end
    assign core_valid = stub_valid | spur;
    assign core_ct    = stub_ct;

    typedef struct {logic [1:0] id; logic [127:0] pt; logic [127:0] ct; logic err;} exp_t;
    exp_t       exp_q[$];
    logic [1:0] rsp_log[$];
    int         m_ptr = 0;
    int         grant_cyc = -10;
    logic       m_busy = 1'b0;
    logic       exp_rv = 1'b0;

    always @(negedge clk) begin
        logic [N-1:0] eg;
        logic         eff_rv;
        exp_t         e;
        int           gid;
        if (!rst_n) begin
            chk("reset_req_ready", req_ready, '0);
            exp_q.delete(); m_ptr = 0; m_busy = 1'b0; exp_rv = 1'b0; grant_cyc = -10;
        end else begin
            eg = m_busy ? '0 : exp_gnt(req_valid, m_ptr);
            chk("req_ready", req_ready, eg);
            chk("req_ready_onehot0", $onehot0(req_ready), 1);
            chk("core_load_timing", core_load, cyc == grant_cyc + 1);
            if (core_load && exp_q.size() > 0) chk("core_pt", core_pt, exp_q[0].pt);
            if (wd_mode) eff_rv = rsp_valid;
            else begin
                chk("rsp_valid", rsp_valid, exp_rv);
                eff_rv = exp_rv;
            end
            if (eff_rv && exp_q.size() > 0) begin
                chk("rsp_id", rsp_id, exp_q[0].id);
                chk("rsp_ct", rsp_ct, exp_q[0].ct);
                chk("rsp_err", rsp_err, exp_q[0].err);
            end
            if (eff_rv && rsp_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                rsp_log.push_back(rsp_id);
                exp_rv = 1'b0; m_busy = 1'b0;
            end else if (!wd_mode && m_busy && !exp_rv && core_valid && cyc > grant_cyc + 1) begin
                exp_rv = 1'b1;
            end
            if (eg != '0) begin
                gid = 0;
                for (int k = 0; k < N; k++) if (eg[k]) gid = k;
                e.id  = 2'(gid);
                e.pt  = req_pt[gid*128 +: 128];
                e.ct  = wd_mode ? '0 : ref_ct(e.pt);
                e.err = wd_mode;
                exp_q.push_back(e);
                m_ptr = (gid + 1) % N; m_busy = 1'b1; grant_cyc = cyc;
            end
        end
    end

    task automatic wait_rsp(input int budget);
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        chk("wait_rsp_valid", rsp_valid, 1);
    endtask

    task automatic drain();
        @(posedge clk); #1;
        req_valid = '0; rsp_ready = 1'b1;
        for (int t = 0; t < 100 && (m_busy || exp_rv); t++) @(negedge clk);
        @(negedge clk);
        chk("drain_idle", {rsp_valid, m_busy}, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int           base;
        logic [127:0] hold_ct, pt3;
        logic [1:0]   hold_id;

        rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b0; spur = 1'b0; mute = 1'b0; wd_mode = 1'b0;
        for (int k = 0; k < N; k++) req_pt[k*128 +: 128] = {$urandom(), $urandom(), $urandom(), $urandom()};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_ct", rsp_ct, '0);
        chk("rst_core_pt", core_pt, '0);
        chk("rst_core_load", core_load, 0);
        @(posedge clk); #1 rst_n = 1'b1; req_valid = '0;

        // Single request on requester 2 with the FIPS-197 block
        @(posedge clk); #1;
        req_pt[2*128 +: 128] = FIPS_PT; req_valid = 4'b0100; rsp_ready = 1'b1;
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(50);
        chk("fips_ct", rsp_ct, FIPS_CT);
        chk("fips_id", rsp_id, 2);
        drain();

        // All requesters asserting continuously
        base = rsp_log.size();
        @(posedge clk); #1 req_valid = '1; rsp_ready = 1'b1;
        for (int t = 0; t < 600 && rsp_log.size() < base + 6; t++) @(negedge clk);
        drain();
        chk("cont_count", (rsp_log.size() >= base + 6), 1);
        for (int k = 0; k < 6; k++)
            if (base + k < rsp_log.size()) chk("cont_seq", rsp_log[base + k], (3 + k) % 4);

        // Backpressure held for 20 cycles in RESP
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_valid = 4'b0011;
        for (int k = 0; k < N; k++) req_pt[k*128 +: 128] = {$urandom(), $urandom(), $urandom(), $urandom()};
        wait_rsp(50);
        #1;
        hold_id = exp_q.size() > 0 ? exp_q[0].id : 2'd0;
        hold_ct = exp_q.size() > 0 ? exp_q[0].ct : '0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk); #1;
            chk("bp_rsp_id", rsp_id, hold_id);
            chk("bp_rsp_ct", rsp_ct, hold_ct);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_req_ready", req_ready, '0);
        end
        drain();

        // Reset pulse while the core is busy
        @(posedge clk); #1 req_valid = 4'b0010; rsp_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (core_load) break;
        end
        chk("mid_core_load_seen", core_load, 1);
        @(posedge clk); #1 req_valid = '0; rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_core_load", core_load, 0);
        chk("mid_rst_core_pt", core_pt, '0);
        chk("mid_rst_rsp_id", rsp_id, 0);
        chk("mid_rst_rsp_ct", rsp_ct, '0);
        chk("mid_rst_rsp_err", rsp_err, 0);
        base = rsp_log.size();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("mid_rst_no_rsp", rsp_valid, 0);
        chk("mid_rst_no_log", rsp_log.size(), base);
        @(posedge clk); #1;
        pt3 = {$urandom(), $urandom(), $urandom(), $urandom()};
        req_pt[3*128 +: 128] = pt3; req_valid = 4'b1000;
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(50);
        chk("post_rst_id", rsp_id, 3);
        chk("post_rst_ct", rsp_ct, ref_ct(pt3));
        drain();

        // Spurious core_valid while idle
        base = rsp_log.size();
        @(posedge clk); #1 spur = 1'b1;
        @(posedge clk); #1 spur = 1'b0;
        repeat (5) @(negedge clk);
        chk("spur_no_rsp", rsp_valid, 0);
        chk("spur_no_log", rsp_log.size(), base);

        // Randomized traffic with requesters coming and going
        for (int t = 0; t < 400; t++) begin
            @(posedge clk); #1;
            req_valid = N'($urandom());
            rsp_ready = 1'($urandom_range(0, 1));
            for (int k = 0; k < N; k++) req_pt[k*128 +: 128] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        drain();

`ifdef AES_SCHED_WATCHDOG_EN
        @(posedge clk); #1 mute = 1'b1; wd_mode = 1'b1; req_valid = 4'b0001; rsp_ready = 1'b0;
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(200);
        chk("wd_rsp_err", rsp_err, 1);
        chk("wd_rsp_ct", rsp_ct, '0);
        drain();
        @(posedge clk); #1 mute = 1'b0; wd_mode = 1'b0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
